// File: rtl/jtag_dtm.sv
// jtag_dtm: JTAG Debug Transport Module, initiator side of the DMI link.
// The JTAG pins are oversampled in the clk domain; scans are turned into
// single-cycle DMI read/write strobes, and read data is returned through
// the dmi data register on the next scan.
//
// Ports:
//   clk, resetn          system clock, synchronous active-low reset
//   jtag_tck/tms/tdi     JTAG inputs (asynchronous, 2-flop synchronized)
//   jtag_tdo             JTAG data out, registered, changes on tck fall
//   dmi_valid            one-clk request strobe
//   dmi_wr               1 = write, 0 = read
//   dmi_addr/dmi_wdata   request address / write data, held until next request
//   dmi_rdata            read data, valid one clk after a read strobe
module jtag_dtm #(
    parameter logic [31:0] IDCODE    = 32'h1000_0001,
    parameter logic [2:0]  IDLE_HINT = 3'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        jtag_tck,
    input  logic        jtag_tms,
    input  logic        jtag_tdi,
    output logic        jtag_tdo,
    output logic        dmi_valid,
    output logic        dmi_wr,
    output logic [6:0]  dmi_addr,
    output logic [31:0] dmi_wdata,
    input  logic [31:0] dmi_rdata
);

    localparam int unsigned IR_W   = 5;
    localparam int unsigned DR_W   = 41;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    localparam logic [IR_W-1:0] IR_IDCODE = 5'h01;
    localparam logic [IR_W-1:0] IR_DTMCS  = 5'h10;
    localparam logic [IR_W-1:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {
        ENG_IDLE, ENG_REQ, ENG_RESP
    } eng_e;

    // Synchronizers and tck edge history
    logic tck_m_q, tck_m_d, tck_s_q, tck_s_d, tck_d_q, tck_d_d;
    logic tms_m_q, tms_m_d, tms_s_q, tms_s_d;
    logic tdi_m_q, tdi_m_d, tdi_s_q, tdi_s_d;

    tap_e              tap_q, tap_d, tap_nxt;
    logic [IR_W-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DR_W-1:0]   dr_sr_q, dr_sr_d;
    logic              tdo_q, tdo_d;

    eng_e              eng_q, eng_d;
    logic              sticky_q, sticky_d;
    logic              valid_q, valid_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_rdata_q, last_rdata_d;

    logic       rise, fall;
    logic       sel_idcode, sel_dtmcs, sel_dmi;
    logic [1:0] dmistat;
    logic       upd_dr, dmi_trig, dmireset, hardreset;

    assign rise = tck_s_q & ~tck_d_q;
    assign fall = ~tck_s_q & tck_d_q;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_dtmcs  = (ir_q == IR_DTMCS);
    assign sel_dmi    = (ir_q == IR_DMI);
    assign dmistat    = sticky_q ? 2'd3 : 2'd0;

    // Update actions happen on the tck fall while sitting in Update-DR
    assign upd_dr    = fall && (tap_q == UPD_DR);
    assign dmi_trig  = upd_dr && sel_dmi && ((dr_sr_q[1:0] == 2'd1) || (dr_sr_q[1:0] == 2'd2));
    assign hardreset = upd_dr && sel_dtmcs && dr_sr_q[17];
    assign dmireset  = upd_dr && sel_dtmcs && (dr_sr_q[16] || dr_sr_q[17]);

    // Pin synchronizers
    always_comb begin
        tck_m_d = jtag_tck;
        tck_s_d = tck_m_q;
        tck_d_d = tck_s_q;
        tms_m_d = jtag_tms;
        tms_s_d = tms_m_q;
        tdi_m_d = jtag_tdi;
        tdi_s_d = tdi_m_q;
    end

    // TAP next state, applied only on a tck rise
    always_comb begin
        tap_nxt = tap_q;
        case (tap_q)
            TLR:     tap_nxt = tms_s_q ? TLR    : RTI;
            RTI:     tap_nxt = tms_s_q ? SEL_DR : RTI;
            SEL_DR:  tap_nxt = tms_s_q ? SEL_IR : CAP_DR;
            CAP_DR:  tap_nxt = tms_s_q ? EX1_DR : SH_DR;
            SH_DR:   tap_nxt = tms_s_q ? EX1_DR : SH_DR;
            EX1_DR:  tap_nxt = tms_s_q ? UPD_DR : PA_DR;
            PA_DR:   tap_nxt = tms_s_q ? EX2_DR : PA_DR;
            EX2_DR:  tap_nxt = tms_s_q ? UPD_DR : SH_DR;
            UPD_DR:  tap_nxt = tms_s_q ? SEL_DR : RTI;
            SEL_IR:  tap_nxt = tms_s_q ? TLR    : CAP_IR;
            CAP_IR:  tap_nxt = tms_s_q ? EX1_IR : SH_IR;
            SH_IR:   tap_nxt = tms_s_q ? EX1_IR : SH_IR;
            EX1_IR:  tap_nxt = tms_s_q ? UPD_IR : PA_IR;
            PA_IR:   tap_nxt = tms_s_q ? EX2_IR : PA_IR;
            EX2_IR:  tap_nxt = tms_s_q ? UPD_IR : SH_IR;
            UPD_IR:  tap_nxt = tms_s_q ? SEL_DR : RTI;
            default: tap_nxt = TLR;
        endcase
        tap_d = rise ? tap_nxt : tap_q;
    end

    // IR / DR capture-shift-update and TDO
    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        dr_sr_d = dr_sr_q;
        tdo_d   = tdo_q;

        if (tap_q == TLR) begin
            ir_d = IR_IDCODE;
        end

        if (rise) begin
            case (tap_q)
                CAP_IR: ir_sr_d = 5'b00001;
                SH_IR:  ir_sr_d = {tdi_s_q, ir_sr_q[IR_W-1:1]};
                CAP_DR: begin
                    if (sel_dmi)
                        dr_sr_d = {last_addr_q, last_rdata_q, dmistat};
                    else if (sel_dtmcs)
                        dr_sr_d = DR_W'({14'b0, 3'b000, IDLE_HINT, dmistat, 6'd7, 4'd1});
                    else if (sel_idcode)
                        dr_sr_d = DR_W'(IDCODE);
                    else
                        dr_sr_d = '0;
                end
                SH_DR: begin
                    // tdi enters the MSB of whichever register is selected
                    if (sel_dmi)
                        dr_sr_d = {tdi_s_q, dr_sr_q[DR_W-1:1]};
                    else if (sel_dtmcs || sel_idcode)
                        dr_sr_d = {9'b0, tdi_s_q, dr_sr_q[31:1]};
                    else
                        dr_sr_d = {40'b0, tdi_s_q};
                end
                default: ;
            endcase
        end

        if (fall) begin
            if (tap_q == UPD_IR)
                ir_d = ir_sr_q;
            if (tap_q == SH_IR)
                tdo_d = ir_sr_q[0];
            else if (tap_q == SH_DR)
                tdo_d = dr_sr_q[0];
            else
                tdo_d = 1'b0;
        end
    end

    // DMI request engine: IDLE -> REQ (strobe) -> RESP (capture read data)
    always_comb begin
        eng_d        = eng_q;
        sticky_d     = sticky_q;
        valid_d      = 1'b0;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_addr_d  = last_addr_q;
        last_rdata_d = last_rdata_q;

        case (eng_q)
            ENG_REQ:  eng_d = ENG_RESP;
            ENG_RESP: begin
                if (!wr_q)
                    last_rdata_d = dmi_rdata;
                eng_d = ENG_IDLE;
            end
            default:  eng_d = ENG_IDLE;
        endcase

        if (dmi_trig) begin
            if ((eng_q != ENG_IDLE) || sticky_q) begin
                sticky_d = 1'b1;
            end else begin
                eng_d       = ENG_REQ;
                valid_d     = 1'b1;
                wr_d        = (dr_sr_q[1:0] == 2'd2);
                addr_d      = dr_sr_q[40:34];
                wdata_d     = dr_sr_q[33:2];
                last_addr_d = dr_sr_q[40:34];
            end
        end

        if (dmireset)
            sticky_d = 1'b0;

        // Hardreset aborts any in-flight cycle without a strobe or data capture
        if (hardreset) begin
            eng_d        = ENG_IDLE;
            valid_d      = 1'b0;
            last_rdata_d = last_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_m_q      <= 1'b0;
            tck_s_q      <= 1'b0;
            tck_d_q      <= 1'b0;
            tms_m_q      <= 1'b0;
            tms_s_q      <= 1'b0;
            tdi_m_q      <= 1'b0;
            tdi_s_q      <= 1'b0;
            tap_q        <= TLR;
            ir_q         <= IR_IDCODE;
            ir_sr_q      <= '0;
            dr_sr_q      <= '0;
            tdo_q        <= 1'b0;
            eng_q        <= ENG_IDLE;
            sticky_q     <= 1'b0;
            valid_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_addr_q  <= '0;
            last_rdata_q <= '0;
        end else begin
            tck_m_q      <= tck_m_d;
            tck_s_q      <= tck_s_d;
            tck_d_q      <= tck_d_d;
            tms_m_q      <= tms_m_d;
            tms_s_q      <= tms_s_d;
            tdi_m_q      <= tdi_m_d;
            tdi_s_q      <= tdi_s_d;
            tap_q        <= tap_d;
            ir_q         <= ir_d;
            ir_sr_q      <= ir_sr_d;
            dr_sr_q      <= dr_sr_d;
            tdo_q        <= tdo_d;
            eng_q        <= eng_d;
            sticky_q     <= sticky_d;
            valid_q      <= valid_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_addr_q  <= last_addr_d;
            last_rdata_q <= last_rdata_d;
        end
    end

    assign jtag_tdo  = tdo_q;
    assign dmi_valid = valid_q;
    assign dmi_wr    = wr_q;
    assign dmi_addr  = addr_q;
    assign dmi_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_dtm.sv
// Scoreboard bench for jtag_dtm: scans and expected DMI strobes are queued
// by the stimulus; a monitor compares them as the DUT produces them.
module tb_jtag_dtm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        jtag_tck = 1'b0;
    logic        jtag_tms = 1'b0;
    logic        jtag_tdi = 1'b0;
    logic        jtag_tdo;
    logic        dmi_valid;
    logic        dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata = 32'h0;

    localparam logic [31:0] RESP_DATA = 32'h1234_5678;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        string       nm;
        logic [63:0] val;
        logic [63:0] mask;
    } scan_t;

    req_t        exp_req_q[$];
    scan_t       exp_scan_q[$];
    logic [63:0] obs_scan_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    jtag_dtm dut (
        .clk       (clk),
        .resetn    (resetn),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo),
        .dmi_valid (dmi_valid),
        .dmi_wr    (dmi_wr),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    always #5 clk = ~clk;

    // Responder: registered read data one clk after a read strobe
    always @(posedge clk) begin
        if (dmi_valid && !dmi_wr)
            dmi_rdata <= RESP_DATA;
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: strobes and completed scans against the queued expectations
    initial begin
        logic  chk_low;
        req_t  r;
        scan_t s;
        logic [63:0] o;
        chk_low = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_low) begin
                check("strobe_width", 64'(dmi_valid), 64'd0);
                chk_low = 1'b0;
            end else if (dmi_valid) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_strobe", 64'(dmi_addr), 64'hFFFF);
                end else begin
                    r = exp_req_q.pop_front();
                    check("dmi_req", 64'({dmi_wr, dmi_addr, dmi_wdata}), 64'({r.wr, r.addr, r.wdata}));
                end
                chk_low = 1'b1;
            end
            while (obs_scan_q.size() > 0 && exp_scan_q.size() > 0) begin
                o = obs_scan_q.pop_front();
                s = exp_scan_q.pop_front();
                check(s.nm, o & s.mask, s.val & s.mask);
            end
        end
    end

    // One tck period: 4 clk low (tms/tdi set, tdo sampled at the end), 4 clk high
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_s);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (4) @(negedge clk);
        tdo_s = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (4) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic b;
        repeat (5) tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
    endtask

    task automatic scan_ir(input logic [4:0] ir, input string nm);
        logic        b;
        logic [63:0] cap;
        scan_t       s;
        s.nm = nm; s.val = 64'h01; s.mask = 64'h1F;
        exp_scan_q.push_back(s);
        cap = '0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_cycle((i == 4), ir[i], b);
            cap[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        obs_scan_q.push_back(cap);
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, input bit chk,
                           input logic [63:0] exp, input logic [63:0] mask, input string nm);
        logic        b;
        logic [63:0] cap;
        scan_t       s;
        if (chk) begin
            s.nm = nm; s.val = exp; s.mask = mask;
            exp_scan_q.push_back(s);
        end
        cap = '0;
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        tck_cycle(1'b0, 1'b0, b);
        for (int i = 0; i < len; i++) begin
            tck_cycle((i == len - 1), din[i], b);
            cap[i] = b;
        end
        tck_cycle(1'b1, 1'b0, b);
        repeat (3) tck_cycle(1'b0, 1'b0, b);
        if (chk)
            obs_scan_q.push_back(cap);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    localparam logic [63:0] M41 = 64'h1FF_FFFF_FFFF;
    localparam logic [63:0] M32 = 64'hFFFF_FFFF;

    initial begin
        req_t r;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_outs", 64'({jtag_tdo, dmi_valid, dmi_wr, dmi_addr, dmi_wdata}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // IDCODE selected after reset
        tap_reset();
        scan_dr(32, 64'd0, 1'b1, 64'h1000_0001, M32, "idcode");

        // DTMCS
        scan_ir(5'h10, "capture_ir_dtmcs");
        scan_dr(32, 64'd0, 1'b1, 64'h0000_1071, M32, "dtmcs");

        // DMI write
        scan_ir(5'h11, "capture_ir_dmi");
        r.wr = 1'b1; r.addr = 7'h04; r.wdata = 32'hDEAD_BEEF;
        exp_req_q.push_back(r);
        scan_dr(41, dmi_word(7'h04, 32'hDEAD_BEEF, 2'd2), 1'b1, 64'd0, M41, "dmi_first_capture");
        check("hold_after_write", 64'({dmi_wr, dmi_addr, dmi_wdata}), 64'({1'b1, 7'h04, 32'hDEAD_BEEF}));

        // DMI read: capture shows the write address and untouched read data
        r.wr = 1'b0; r.addr = 7'h10; r.wdata = 32'h0;
        exp_req_q.push_back(r);
        scan_dr(41, dmi_word(7'h10, 32'h0, 2'd1), 1'b1, dmi_word(7'h04, 32'h0, 2'd0), M41, "capture_after_write");

        // Read data returned; op=3 is a no-op and changes nothing
        scan_dr(41, dmi_word(7'h55, 32'hCAFE_0000, 2'd3), 1'b1, dmi_word(7'h10, RESP_DATA, 2'd0), M41, "capture_after_read");
        scan_dr(41, 64'd0, 1'b1, dmi_word(7'h10, RESP_DATA, 2'd0), M41, "capture_after_op3");

        // BYPASS: tdo is tdi delayed by one bit, first bit 0
        scan_ir(5'h07, "capture_ir_bypass");
        scan_dr(8, 64'hA5, 1'b1, 64'h4A, 64'hFF, "bypass");

        // Test-Logic-Reset restores IDCODE selection
        tap_reset();
        scan_dr(32, 64'd0, 1'b1, 64'h1000_0001, M32, "idcode_after_tlr");

        // Reset asserted while the read strobe is out aborts the engine
        scan_ir(5'h11, "capture_ir_dmi2");
        r.wr = 1'b0; r.addr = 7'h22; r.wdata = 32'h0;
        exp_req_q.push_back(r);
        fork
            scan_dr(41, dmi_word(7'h22, 32'h0, 2'd1), 1'b0, 64'd0, 64'd0, "");
            begin
                int n;
                n = 0;
                while (!dmi_valid && n < 3000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("strobe_before_reset", 64'(dmi_valid), 64'd1);
                resetn = 1'b0;
                @(posedge clk);
                #1;
                check("abort_outs", 64'({jtag_tdo, dmi_valid, dmi_wr, dmi_addr, dmi_wdata}), 64'd0);
                repeat (2) @(negedge clk);
                resetn = 1'b1;
            end
        join
        tap_reset();
        scan_ir(5'h11, "capture_ir_dmi3");
        scan_dr(41, 64'd0, 1'b1, 64'd0, 64'h3_FFFF_FFFF, "capture_after_abort");

        repeat (20) @(negedge clk);
        check("pending_strobes", 64'(exp_req_q.size()), 64'd0);
        check("pending_scans", 64'(exp_scan_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_assert++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
